// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster constants and coordinate type
package vga_timing_pkg;

  // Default 640x480@60 timing, in pixels and lines
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Pixel coordinate shared by the timing generator and every sprite renderer
  typedef logic [9:0] coord_t;

  // Narrow an elaboration-time integer to a coordinate
  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - N-stage shift register with a selectable reset value
module sync_delay #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  if (N == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [N-1:0] stage_q;
    logic [N-1:0] stage_d;

    // Shift the input one stage further along the chain each cycle
    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = d;
      for (int i = 1; i < N; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Chain registers, all stages forced to the reset value asynchronously
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= {N{rst_val}};
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q = stage_q[N-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster counters with delayed sync
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIPE_DLY = 1
) (
  input  logic   vga_clk,
  input  logic   reset,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   line_start,
  output logic   frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1024) begin : g_h_total_too_big
    $error("vga_timing_gen: horizontal total exceeds 10-bit counter");
  end
  if (V_TOT > 1024) begin : g_v_total_too_big
    $error("vga_timing_gen: vertical total exceeds 10-bit counter");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_pipe_dly_range
    $error("vga_timing_gen: PIPE_DLY must be 0..4");
  end

  localparam coord_t H_LAST   = to_coord(H_TOT - 1);
  localparam coord_t V_LAST   = to_coord(V_TOT - 1);
  localparam coord_t H_VIS    = to_coord(H_ACTIVE);
  localparam coord_t V_VIS    = to_coord(V_ACTIVE);
  localparam coord_t HS_FIRST = to_coord(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = to_coord(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = to_coord(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = to_coord(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t hc_q, hc_d;
  coord_t vc_q, vc_d;
  logic   hs_raw;
  logic   vs_raw;

  // Next raster position: step along the line, wrap into the next line and frame
  always_comb begin
    hc_d = hc_q + coord_t'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d = '0;
      end else begin
        vc_d = vc_q + coord_t'(1);
      end
    end
  end

  // Raster counters, cleared immediately on reset with no partial-line finish
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Decode visibility, line/frame markers and undelayed sync from the counters only
  always_comb begin
    blank       = (hc_q < H_VIS) && (vc_q < V_VIS);
    line_start  = (hc_q == '0);
    frame_start = (hc_q == '0) && (vc_q == '0);
    hs_raw      = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
    vs_raw      = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
  end

  assign DrawX = hc_q;
  assign DrawY = vc_q;

  // Sync is delayed to line up with sprite colour registered one pixel later
  sync_delay #(.N(PIPE_DLY)) u_hs_dly (
    .clk     (vga_clk),
    .rst     (reset),
    .rst_val (1'b1),
    .d       (hs_raw),
    .q       (hs)
  );

  sync_delay #(.N(PIPE_DLY)) u_vs_dly (
    .clk     (vga_clk),
    .rst     (reset),
    .rst_val (1'b1),
    .d       (vs_raw),
    .q       (vs)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a scaled raster
module tb_vga_timing_gen;

  // Scaled raster geometry with the same structure as 640x480
  localparam int HA    = 64;
  localparam int HF    = 4;
  localparam int HSW   = 8;
  localparam int HB    = 4;
  localparam int VA    = 48;
  localparam int VF    = 3;
  localparam int VSW   = 2;
  localparam int VB    = 4;
  localparam int HT    = HA + HF + HSW + HB;
  localparam int VT    = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] DrawX, DrawY, x3, y3;
  logic       blank, hs, vs, line_start, frame_start;
  logic       blank3, hs3, vs3, ls3, fs3;

  int     checks = 0;
  int     errors = 0;
  longint t;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_DLY(1)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .hs(hs), .vs(vs), .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_DLY(3)
  ) dut3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(x3), .DrawY(y3),
    .blank(blank3), .hs(hs3), .vs(vs3), .line_start(ls3), .frame_start(fs3)
  );

  always #20 vga_clk = ~vga_clk;

  // Model time: pixel clocks elapsed since reset was released
  always @(posedge vga_clk or posedge reset) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  function automatic int mx(input longint c);
    return int'(c % HT);
  endfunction

  function automatic int my(input longint c);
    return int'((c / HT) % VT);
  endfunction

  function automatic logic m_hs(input longint c, input int d);
    int x;
    if (c < longint'(d)) return 1'b1;
    x = mx(c - longint'(d));
    return !(x >= HA + HF && x < HA + HF + HSW);
  endfunction

  function automatic logic m_vs(input longint c, input int d);
    int y;
    if (c < longint'(d)) return 1'b1;
    y = my(c - longint'(d));
    return !(y >= VA + VF && y < VA + VF + VSW);
  endfunction

  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(DrawX == 10'(x) && DrawY == 10'(y)) && n < 2 * FRAME) begin
      @(negedge vga_clk);
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin
      errors++;
      $display("FAIL run_to timeout: at x=%0d y=%0d, wanted x=%0d y=%0d", DrawX, DrawY, x, y);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) begin
      @(negedge vga_clk);
      checks += 5;
      if (DrawX !== 10'd0 || DrawY !== 10'd0) begin
        errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", DrawX, DrawY);
      end
      if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b want 1", blank); end
      if (hs !== 1'b1 || vs !== 1'b1 || hs3 !== 1'b1 || vs3 !== 1'b1) begin
        errors++; $display("FAIL reset_sync: got hs=%b vs=%b hs3=%b vs3=%b want 1", hs, vs, hs3, vs3);
      end
      if (frame_start !== 1'b1) begin errors++; $display("FAIL reset_frame_start: got %b want 1", frame_start); end
      if (line_start !== 1'b1) begin errors++; $display("FAIL reset_line_start: got %b want 1", line_start); end
    end
    reset = 1'b0;
    @(negedge vga_clk);
    checks += 2;
    if (DrawX !== 10'd1) begin errors++; $display("FAIL release_x: got %0d want 1", DrawX); end
    if (DrawY !== 10'd0) begin errors++; $display("FAIL release_y: got %0d want 0", DrawY); end
  endtask

  task automatic test_line_wrap;
    run_to(HT - 1, 0);
    @(negedge vga_clk);
    checks += 3;
    if (DrawX !== 10'd0 || DrawY !== 10'd1) begin
      errors++; $display("FAIL wrap_xy: got %0d,%0d want 0,1", DrawX, DrawY);
    end
    if (line_start !== 1'b1) begin errors++; $display("FAIL wrap_line_start: got %b want 1", line_start); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL wrap_frame_start: got %b want 0", frame_start); end
    @(negedge vga_clk);
    checks++;
    if (line_start !== 1'b0) begin errors++; $display("FAIL wrap_line_pulse_len: got %b want 0", line_start); end
  endtask

  task automatic test_blank;
    run_to(HA - 1, 1);
    checks++;
    if (blank !== 1'b1) begin errors++; $display("FAIL blank_last_visible_x: got %b want 1", blank); end
    @(negedge vga_clk);
    checks++;
    if (blank !== 1'b0) begin errors++; $display("FAIL blank_first_hidden_x: got %b want 0", blank); end
    run_to(0, VA - 1);
    checks++;
    if (blank !== 1'b1) begin errors++; $display("FAIL blank_last_visible_y: got %b want 1", blank); end
    run_to(0, VA);
    checks++;
    if (blank !== 1'b0) begin errors++; $display("FAIL blank_first_hidden_y: got %b want 0", blank); end
  endtask

  task automatic test_hsync;
    int first_x = -1;
    int lows    = 0;
    run_to(0, VA + 1);
    repeat (HT) begin
      if (hs === 1'b0) begin
        if (first_x < 0) first_x = int'(DrawX);
        lows++;
      end
      @(negedge vga_clk);
    end
    checks += 2;
    if (first_x != HA + HF + 1) begin errors++; $display("FAIL hs_first_low_x: got %0d want %0d", first_x, HA + HF + 1); end
    if (lows != HSW) begin errors++; $display("FAIL hs_low_width: got %0d want %0d", lows, HSW); end
  endtask

  task automatic test_vsync;
    int first_x = -1;
    int first_y = -1;
    int lows    = 0;
    run_to(0, VA + VF - 1);
    repeat (4 * HT) begin
      if (vs === 1'b0) begin
        if (first_x < 0) begin first_x = int'(DrawX); first_y = int'(DrawY); end
        lows++;
      end
      @(negedge vga_clk);
    end
    checks += 2;
    if (first_x != 1 || first_y != VA + VF) begin
      errors++; $display("FAIL vs_first_low: got %0d,%0d want 1,%0d", first_x, first_y, VA + VF);
    end
    if (lows != VSW * HT) begin errors++; $display("FAIL vs_low_width: got %0d want %0d", lows, VSW * HT); end
  endtask

  task automatic test_frame_period;
    int cycles = 0;
    int lines  = 0;
    run_to(0, 0);
    do begin
      if (line_start === 1'b1) lines++;
      @(negedge vga_clk);
      cycles++;
    end while (frame_start !== 1'b1 && cycles < 2 * FRAME);
    checks += 2;
    if (cycles != FRAME) begin errors++; $display("FAIL frame_cycles: got %0d want %0d", cycles, FRAME); end
    if (lines != VT) begin errors++; $display("FAIL frame_lines: got %0d want %0d", lines, VT); end
  endtask

  task automatic test_mid_reset;
    int cycles = 0;
    run_to(HA + HF + int'($urandom_range(3, HSW - 1)), VA + VF);
    checks++;
    if (hs !== 1'b0 || vs !== 1'b0 || hs3 !== 1'b0 || vs3 !== 1'b0) begin
      errors++; $display("FAIL midrst_pre_sync: got hs=%b vs=%b hs3=%b vs3=%b want 0", hs, vs, hs3, vs3);
    end
    #($urandom_range(2, 15));
    reset = 1'b1;
    #1;
    checks += 2;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || x3 !== 10'd0 || y3 !== 10'd0) begin
      errors++; $display("FAIL midrst_xy: got %0d,%0d want 0,0", DrawX, DrawY);
    end
    if (hs !== 1'b1 || vs !== 1'b1 || hs3 !== 1'b1 || vs3 !== 1'b1) begin
      errors++; $display("FAIL midrst_sync: got hs=%b vs=%b hs3=%b vs3=%b want 1", hs, vs, hs3, vs3);
    end
    repeat (2) @(negedge vga_clk);
    reset = 1'b0;
    do begin
      @(negedge vga_clk);
      cycles++;
    end while (frame_start !== 1'b1 && cycles < 2 * FRAME);
    checks++;
    if (cycles != FRAME) begin errors++; $display("FAIL midrst_next_frame: got %0d want %0d", cycles, FRAME); end
  endtask

  task automatic test_random;
    int ex, ey;
    for (int it = 0; it < 6; it++) begin
      int len = int'($urandom_range(200, 2500));
      for (int k = 0; k < len; k++) begin
        @(negedge vga_clk);
        ex = mx(t);
        ey = my(t);
        checks += 6;
        if (DrawX !== 10'(ex) || DrawY !== 10'(ey) || x3 !== 10'(ex) || y3 !== 10'(ey)) begin
          errors++; $display("FAIL rnd_xy t=%0d: got %0d,%0d / %0d,%0d want %0d,%0d", t, DrawX, DrawY, x3, y3, ex, ey);
        end
        if (blank !== (ex < HA && ey < VA) || blank3 !== blank) begin
          errors++; $display("FAIL rnd_blank t=%0d: got %b/%b want %b", t, blank, blank3, (ex < HA && ey < VA));
        end
        if (line_start !== (ex == 0) || ls3 !== (ex == 0)) begin
          errors++; $display("FAIL rnd_line_start t=%0d: got %b/%b want %b", t, line_start, ls3, (ex == 0));
        end
        if (frame_start !== (ex == 0 && ey == 0) || fs3 !== (ex == 0 && ey == 0)) begin
          errors++; $display("FAIL rnd_frame_start t=%0d: got %b/%b want %b", t, frame_start, fs3, (ex == 0 && ey == 0));
        end
        if (hs !== m_hs(t, 1) || vs !== m_vs(t, 1)) begin
          errors++; $display("FAIL rnd_sync_d1 t=%0d: got hs=%b vs=%b want hs=%b vs=%b", t, hs, vs, m_hs(t, 1), m_vs(t, 1));
        end
        if (hs3 !== m_hs(t, 3) || vs3 !== m_vs(t, 3)) begin
          errors++; $display("FAIL rnd_sync_d3 t=%0d: got hs=%b vs=%b want hs=%b vs=%b", t, hs3, vs3, m_hs(t, 3), m_vs(t, 3));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        #($urandom_range(1, 18));
        reset = 1'b1;
        #1;
        checks++;
        if (DrawX !== 10'd0 || DrawY !== 10'd0 || hs !== 1'b1 || vs !== 1'b1) begin
          errors++; $display("FAIL rnd_async_reset: got x=%0d y=%0d hs=%b vs=%b want 0,0,1,1", DrawX, DrawY, hs, vs);
        end
        repeat (int'($urandom_range(1, 3))) @(negedge vga_clk);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_blank();
    test_hsync();
    test_vsync();
    test_frame_period();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
